// File: rtl/mii_frame_receiver.sv
// mii_frame_receiver
//   Receives one Ethernet frame from a 4-bit MII PHY. It synchronises the PHY
//   pins into the clk domain, strips the preamble/SFD, and emits payload bytes
//   (low nibble first) with a one-cycle strobe. Reception of one frame is armed
//   by the start level.
//
// Ports
//   clk              system clock; all logic runs in this domain
//   reset            asynchronous, active-low reset
//   start            level; arms reception of one frame
//   ethernet_rx_clk  MII receive clock, asynchronous to clk (clk >= 3x rx clk)
//   ethernet_rx_dv   MII receive data valid
//   ethernet_rx      MII receive nibble
//   frame_ready      one-cycle strobe: frame holds a new payload byte
//   frame            received payload byte, held until the next byte
module mii_frame_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ethernet_rx_clk,
  input  logic       ethernet_rx_dv,
  input  logic [3:0] ethernet_rx,
  output logic       frame_ready,
  output logic [7:0] frame
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PREAMBLE = 2'b01,
    PAYLOAD  = 2'b10,
    DONE     = 2'b11
  } state_t;

  state_t state_reg, state_next;

  // Input synchronisers
  logic [SYNC_STAGES-1:0]      clk_sync;
  logic [SYNC_STAGES-1:0]      dv_sync;
  logic [SYNC_STAGES-1:0][3:0] nib_sync;
  logic                        clk_prev;
  logic                        rx_rise;
  logic                        sample_en;
  logic                        cap_dv;
  logic [3:0]                  cap_nib;

  // Receive datapath state
  logic             phase_reg, phase_next;
  logic [3:0]       low_reg, low_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dv_seen_reg, dv_seen_next;
  logic             frame_ready_next;
  logic [7:0]       frame_next;
  logic [7:0]       byte_in;

  assign rx_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;

  // dv and nibble pass through the same number of stages as rx_clk, so at the
  // detected rising edge they carry the values the PHY held across that edge.
  // sample_en is registered alongside the captured data so both arrive together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '0;
      dv_sync   <= '0;
      nib_sync  <= '0;
      clk_prev  <= 1'b0;
      sample_en <= 1'b0;
      cap_dv    <= 1'b0;
      cap_nib   <= '0;
    end else begin
      clk_sync[0] <= ethernet_rx_clk;
      dv_sync[0]  <= ethernet_rx_dv;
      nib_sync[0] <= ethernet_rx;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i] <= clk_sync[i-1];
        dv_sync[i]  <= dv_sync[i-1];
        nib_sync[i] <= nib_sync[i-1];
      end
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      sample_en <= rx_rise;
      if (rx_rise) begin
        cap_dv  <= dv_sync[SYNC_STAGES-1];
        cap_nib <= nib_sync[SYNC_STAGES-1];
      end
    end
  end

  assign byte_in = {cap_nib, low_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      phase_reg   <= 1'b0;
      low_reg     <= '0;
      cnt_reg     <= '0;
      dv_seen_reg <= 1'b0;
      frame_ready <= 1'b0;
      frame       <= '0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      low_reg     <= low_next;
      cnt_reg     <= cnt_next;
      dv_seen_reg <= dv_seen_next;
      frame_ready <= frame_ready_next;
      frame       <= frame_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    phase_next       = phase_reg;
    low_next         = low_reg;
    cnt_next         = cnt_reg;
    dv_seen_next     = dv_seen_reg;
    frame_ready_next = 1'b0;
    frame_next       = frame;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = PREAMBLE;
          cnt_next     = '0;
          dv_seen_next = 1'b0;
          phase_next   = 1'b0;
        end
      end

      PREAMBLE: begin
        if (sample_en && cap_dv) dv_seen_next = 1'b1;
        // The timeout only runs until the first valid sample; after that the
        // hunt waits for an SFD indefinitely.
        if (!dv_seen_reg && cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end else begin
          if (!dv_seen_reg) cnt_next = cnt_reg + 1'b1;
          if (sample_en) begin
            if (!cap_dv) begin
              phase_next = 1'b0;
            end else if (!phase_reg) begin
              low_next   = cap_nib;
              phase_next = 1'b1;
            end else begin
              // 0x55 keeps hunting, 0xD5 is the SFD, anything else restarts
              // the byte alignment; all three leave phase at 0.
              phase_next = 1'b0;
              if (byte_in == 8'hD5) state_next = PAYLOAD;
            end
          end
        end
      end

      PAYLOAD: begin
        if (sample_en) begin
          if (!cap_dv) begin
            // A pending low nibble is simply dropped.
            state_next = DONE;
            phase_next = 1'b0;
          end else if (!phase_reg) begin
            low_next   = cap_nib;
            phase_next = 1'b1;
          end else begin
            frame_next       = byte_in;
            frame_ready_next = 1'b1;
            phase_next       = 1'b0;
          end
        end
      end

      DONE: begin
        if (!start) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mii_frame_receiver.sv
module tb_mii_frame_receiver;

  localparam int unsigned TO = 32;
  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_PREAMBLE = 2'b01;
  localparam logic [1:0] S_PAYLOAD  = 2'b10;
  localparam logic [1:0] S_DONE     = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rx_clk;
  logic       rx_dv;
  logic [3:0] rx_nib;
  logic       frame_ready;
  logic [7:0] frame;
  logic [1:0] st;

  always #5 clk = ~clk;

  mii_frame_receiver #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .ethernet_rx_clk (rx_clk),
    .ethernet_rx_dv  (rx_dv),
    .ethernet_rx     (rx_nib),
    .frame_ready     (frame_ready),
    .frame           (frame)
  );

  assign st = dut.state_reg;

  int         n_cmp  = 0;
  int         n_err  = 0;
  int         pulses = 0;
  logic [7:0] sb[$];
  logic       fr_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: every strobe pops one expected byte.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (reset === 1'b1 && frame_ready === 1'b1) begin
      pulses++;
      if (fr_prev) begin
        n_cmp++;
        n_err++;
        $display("FAIL strobe_width: frame_ready high 2 cycles expected 1");
      end
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_byte: got %02h expected no strobe", frame);
      end else begin
        e = sb.pop_front();
        chk("frame_byte", 32'(frame), 32'(e));
      end
    end
    fr_prev = frame_ready;
  end

  // MII: data changes just after the falling edge, stable across the rising edge.
  task automatic send_nib(input logic dv, input logic [3:0] n);
    rx_dv  = dv;
    rx_nib = n;
    #20 rx_clk = 1'b1;
    #20 rx_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(1'b1, b[3:0]);
    send_nib(1'b1, b[7:4]);
  endtask

  task automatic idle_nibs(input int k);
    for (int i = 0; i < k; i++) send_nib(1'b0, 4'h0);
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output int cyc);
    cyc = -1;
    if (st == s) cyc = 0;
    for (int i = 1; i <= max && cyc < 0; i++) begin
      @(negedge clk);
      if (st == s) cyc = i;
    end
  endtask

  typedef struct {
    int unsigned     n_bytes;
    logic [11:0][7:0] bytes;
    logic            has_tail;
    logic [3:0]      tail;
    int unsigned     n_exp;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    int p0;

    // Concatenations list bytes last-first so element 0 is sent first.
    vecs[0].n_bytes = 11; vecs[0].bytes = {8'hFF, 8'h3C, 8'hA1, 8'hD5, {7{8'h55}}};
    vecs[0].has_tail = 1'b0; vecs[0].tail = 4'h0;
    vecs[0].n_exp = 3; vecs[0].exp = {8'h00, 8'hFF, 8'h3C, 8'hA1};

    vecs[1].n_bytes = 9; vecs[1].bytes = {8'hA1, 8'hD5, {7{8'h55}}};
    vecs[1].has_tail = 1'b1; vecs[1].tail = 4'h7;
    vecs[1].n_exp = 1; vecs[1].exp = {24'h0, 8'hA1};

    vecs[2].n_bytes = 6; vecs[2].bytes = {8'h42, 8'hD5, 8'h55, 8'h45, 8'h55, 8'h55};
    vecs[2].has_tail = 1'b0; vecs[2].tail = 4'h0;
    vecs[2].n_exp = 1; vecs[2].exp = {24'h0, 8'h42};

    vecs[3].n_bytes = 2; vecs[3].bytes = {8'h5A, 8'hD5};
    vecs[3].has_tail = 1'b0; vecs[3].tail = 4'h0;
    vecs[3].n_exp = 1; vecs[3].exp = {24'h0, 8'h5A};

    vecs[4].n_bytes = 5; vecs[4].bytes = {8'h0F, 8'hF0, 8'h00, 8'hD5, 8'h55};
    vecs[4].has_tail = 1'b0; vecs[4].tail = 4'h0;
    vecs[4].n_exp = 3; vecs[4].exp = {8'h00, 8'h0F, 8'hF0, 8'h00};

    // Reset state
    reset = 1'b0; start = 1'b0; rx_clk = 1'b0; rx_dv = 1'b0; rx_nib = 4'h0;
    #10;
    chk("reset_frame_ready", 32'(frame_ready), 32'h0);
    chk("reset_frame", 32'(frame), 32'h0);
    chk("reset_state", 32'(st), 32'(S_IDLE));
    @(negedge clk); reset = 1'b1;

    // Timeout with no MII activity
    @(negedge clk); start = 1'b1;
    wait_state(S_DONE, 100, c);
    chk("timeout_reached", 32'(c >= 0), 32'h1);
    chk("timeout_window", 32'(c >= TO && c <= TO + 2), 32'h1);
    chk("timeout_no_strobe", 32'(pulses), 32'h0);
    chk("timeout_frame", 32'(frame), 32'h0);

    // Table-driven frames; each starts from DONE by dropping start
    for (int v = 0; v < 5; v++) begin
      @(negedge clk); start = 1'b0;
      wait_state(S_IDLE, 20, c);
      chk("done_to_idle", 32'(c >= 0), 32'h1);
      p0 = pulses;
      for (int unsigned k = 0; k < vecs[v].n_exp; k++) sb.push_back(vecs[v].exp[k]);
      @(negedge clk); start = 1'b1;
      for (int unsigned k = 0; k < vecs[v].n_bytes; k++) send_byte(vecs[v].bytes[k]);
      if (vecs[v].has_tail) send_nib(1'b1, vecs[v].tail);
      idle_nibs(2);
      wait_state(S_DONE, 40, c);
      chk("frame_done", 32'(c >= 0), 32'h1);
      repeat (10) @(negedge clk);
      chk("done_hold", 32'(st), 32'(S_DONE));
      chk("pulse_count", 32'(pulses - p0), 32'(vecs[v].n_exp));
      chk("sb_drained", 32'(sb.size()), 32'h0);
      sb.delete();
    end

    // Reset asserted mid-payload
    @(negedge clk); start = 1'b0;
    wait_state(S_IDLE, 20, c);
    chk("pre_abort_idle", 32'(c >= 0), 32'h1);
    sb.push_back(8'h11);
    @(negedge clk); start = 1'b1;
    send_byte(8'h55);
    send_byte(8'hD5);
    send_byte(8'h11);
    send_nib(1'b1, 4'h2);
    repeat (2) @(negedge clk);
    chk("abort_in_payload", 32'(st), 32'(S_PAYLOAD));
    chk("abort_first_byte", 32'(frame), 32'h11);
    p0 = pulses;
    reset = 1'b0;
    #1;
    chk("abort_frame_ready", 32'(frame_ready), 32'h0);
    chk("abort_frame", 32'(frame), 32'h0);
    chk("abort_state", 32'(st), 32'(S_IDLE));
    start = 1'b0;
    send_nib(1'b1, 4'h4);
    @(negedge clk); reset = 1'b1;
    send_byte(8'hD5);
    send_byte(8'h77);
    idle_nibs(2);
    repeat (10) @(negedge clk);
    chk("post_abort_idle", 32'(st), 32'(S_IDLE));
    chk("post_abort_no_strobe", 32'(pulses - p0), 32'h0);
    chk("post_abort_sb", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
